// File: rtl/div_pkg.sv
// Shared types and width helpers for the iterative non-restoring mantissa divider.
package div_pkg;
   localparam int MANT_W_DEF = 24;
   localparam int WIDTH_DEF  = 28;

   typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_e;

   // Partial remainder needs one bit for the 2R headroom and one for sign.
   function automatic int rem_w(input int mant_w);
      return mant_w + 2;
   endfunction

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction
endpackage

// File: rtl/nr_step.sv
// One radix-2 non-restoring digit: picks the digit from the sign of R, then adds or subtracts b.
module nr_step #(
   parameter int MANT_W = 24,
   parameter int REM_W  = 26
) (
   input  logic signed [REM_W-1:0] r,
   input  logic [MANT_W-1:0]       b,
   input  logic                    first,
   output logic signed [REM_W-1:0] r_next,
   output logic                    p_bit
);
   logic signed [REM_W-1:0] b_ext;
   logic signed [REM_W-1:0] sh;

   assign b_ext  = signed'({{(REM_W-MANT_W){1'b0}}, b});
   assign p_bit  = ~r[REM_W-1];
   // The dividend enters unshifted so the quotient lands in Q1.(WIDTH-1).
   assign sh     = first ? r : (r <<< 1);
   assign r_next = p_bit ? (sh - b_ext) : (sh + b_ext);
endmodule

// File: rtl/div_nr_iter.sv
// Iterative radix-2 non-restoring divider, one quotient digit per clock, optional
// correction cycle so the final remainder is non-negative.
module div_nr_iter
   import div_pkg::*;
#(
   parameter int MANT_W  = MANT_W_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int CORRECT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W-1:0] a,
   input  logic [MANT_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  q,
   output logic              rem_is_positive,
   output logic              rem_is_negative,
   output logic              rem_is_zero,
   output logic              invalid
);
   localparam int REM_W = rem_w(MANT_W);
   localparam int CNT_W = cnt_w(WIDTH);

   state_e                  state;
   logic signed [REM_W-1:0] r, r_next, r_corr, r_fix;
   logic [MANT_W-1:0]       b_q;
   logic [CNT_W-1:0]        cnt;
   logic [WIDTH-1:0]        p, p_next, q_raw;
   logic                    p_bit, last;

   nr_step #(.MANT_W(MANT_W), .REM_W(REM_W)) u_step (
      .r      (r),
      .b      (b_q),
      .first  (cnt == '0),
      .r_next (r_next),
      .p_bit  (p_bit)
   );

   assign last   = (cnt == CNT_W'(WIDTH-1));
   assign p_next = (p << 1) | WIDTH'(p_bit);
   // Digits are +1/-1 encoded in P; Q = 2P - (2^WIDTH - 1) reduces to 2P + 1 mod 2^WIDTH.
   assign q_raw  = (p_next << 1) + WIDTH'(1);
   assign r_corr = r + signed'({2'b00, b_q});
   assign r_fix  = r[REM_W-1] ? r_corr : r;

   function automatic logic [2:0] sign3(input logic signed [REM_W-1:0] v);
      return {(!v[REM_W-1] && (v != '0)), v[REM_W-1], (v == '0)};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         q         <= '0;
         invalid   <= 1'b0;
         cnt       <= '0;
         r         <= '0;
         b_q       <= '0;
         p         <= '0;
         {rem_is_positive, rem_is_negative, rem_is_zero} <= 3'b000;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               b_q      <= b;
               r        <= signed'({2'b00, a});
               cnt      <= '0;
               p        <= '0;
               in_ready <= 1'b0;
               if (!b[MANT_W-1]) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  q         <= '1;
                  invalid   <= 1'b1;
                  {rem_is_positive, rem_is_negative, rem_is_zero} <= 3'b000;
               end else begin
                  state   <= ITER;
                  invalid <= 1'b0;
               end
            end
            ITER: begin
               r   <= r_next;
               p   <= p_next;
               cnt <= cnt + 1'b1;
               if (last) begin
                  q <= q_raw;
                  if (CORRECT != 0) begin
                     state <= CORR;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     {rem_is_positive, rem_is_negative, rem_is_zero} <= sign3(r_next);
                  end
               end
            end
            CORR: begin
               state     <= DONE;
               out_valid <= 1'b1;
               r         <= r_fix;
               if (r[REM_W-1]) q <= q - 1'b1;
               {rem_is_positive, rem_is_negative, rem_is_zero} <= sign3(r_fix);
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_nr_iter.sv
// Bench for div_nr_iter: one instance per CORRECT setting, checked against a
// quotient/remainder model built from plain integer division.
module tb_div_nr_iter;
   localparam int MW = 24;
   localparam int W  = 28;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [1:0] in_valid = '0, out_ready = '0;
   logic [1:0] in_ready, out_valid, rpos, rneg, rzero, invalid;
   logic [1:0][MW-1:0] a = '0, b = '0;
   logic [1:0][W-1:0]  q;
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   div_nr_iter #(.MANT_W(MW), .WIDTH(W), .CORRECT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .q(q[0]), .rem_is_positive(rpos[0]), .rem_is_negative(rneg[0]),
      .rem_is_zero(rzero[0]), .invalid(invalid[0]));

   div_nr_iter #(.MANT_W(MW), .WIDTH(W), .CORRECT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .q(q[1]), .rem_is_positive(rpos[1]), .rem_is_negative(rneg[1]),
      .rem_is_zero(rzero[1]), .invalid(invalid[1]));

   // Raw non-restoring result is the unique odd Q with -b <= R < b; corrected is floor division.
   task automatic model(input int k, input logic [MW-1:0] av, input logic [MW-1:0] bv,
                        output logic [W-1:0] qe, output logic [2:0] fe, output logic ie);
      longint n, qt, r;
      if (!bv[MW-1]) begin
         qe = '1; fe = 3'b000; ie = 1'b1;
         return;
      end
      n  = longint'(av) << (W-1);
      qt = n / longint'(bv);
      r  = n % longint'(bv);
      if (k == 0 && (qt % 2) == 0) begin
         qt = qt + 1;
         r  = r - longint'(bv);
      end
      qe = qt[W-1:0];
      fe = {r > 0, r < 0, r == 0};
      ie = 1'b0;
   endtask

   task automatic do_div(input int k, input logic [MW-1:0] av, input logic [MW-1:0] bv,
                         input int hold, output logic [W-1:0] qo, output logic [2:0] fo,
                         output logic io, output int lat);
      int n;
      n = 0;
      qo = 'x; fo = 'x; io = 1'bx;
      while (!in_ready[k] && n < 100) begin @(posedge clk); #1; n++; end
      a[k] = av; b[k] = bv; in_valid[k] = 1'b1;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      lat = 1;
      while (!out_valid[k] && lat < 100) begin @(posedge clk); #1; lat++; end
      if (!out_valid[k]) begin
         n_cmp++; n_err++;
         $display("FAIL timeout k=%0d a=%h b=%h: out_valid=0 required 1", k, av, bv);
         return;
      end
      qo = q[k]; fo = {rpos[k], rneg[k], rzero[k]}; io = invalid[k];
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if ({out_valid[k], q[k], rpos[k], rneg[k], rzero[k], invalid[k]} !== {1'b1, qo, fo, io}) begin
            n_err++;
            $display("FAIL hold_stable k=%0d cyc=%0d: got v=%b q=%h f=%b%b%b required v=1 q=%h f=%b",
                     k, i, out_valid[k], q[k], rpos[k], rneg[k], rzero[k], qo, fo);
         end
      end
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      n_cmp++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
         n_err++;
         $display("FAIL handshake k=%0d: out_valid=%b in_ready=%b required 0/1", k, out_valid[k], in_ready[k]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if ({in_ready[k], out_valid[k], q[k], rpos[k], rneg[k], rzero[k], invalid[k]} !== {1'b1, 1'b0, {W{1'b0}}, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_state k=%0d: rdy=%b v=%b q=%h f=%b%b%b inv=%b required 1 0 0 000 0",
                     k, in_ready[k], out_valid[k], q[k], rpos[k], rneg[k], rzero[k], invalid[k]);
         end
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int            kk[5]  = '{0, 1, 1, 0, 1};
      logic [MW-1:0] av[5]  = '{24'h800000, 24'h800000, 24'hC00000, 24'h800000, 24'hFFFFFF};
      logic [MW-1:0] bv[5]  = '{24'h800000, 24'h800000, 24'h800000, 24'h400000, 24'h000000};
      logic [W-1:0]  qx[5]  = '{28'h8000001, 28'h8000000, 28'hC000000, 28'hFFFFFFF, 28'hFFFFFFF};
      logic [3:0]    fx[5]  = '{4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
      int            lx[5]  = '{W+1, W+2, W+2, 1, 1};
      logic [W-1:0]  qo;
      logic [2:0]    fo;
      logic          io;
      int            lat;
      for (int i = 0; i < 5; i++) begin
         do_div(kk[i], av[i], bv[i], 0, qo, fo, io, lat);
         n_cmp++;
         if ({qo, fo, io} !== {qx[i], fx[i]}) begin
            n_err++;
            $display("FAIL directed_%0d: q=%h pnz=%b inv=%b required q=%h pnz/inv=%b", i, qo, fo, io, qx[i], fx[i]);
         end
         n_cmp++;
         if (lat != lx[i]) begin
            n_err++;
            $display("FAIL directed_lat_%0d: latency=%0d required %0d", i, lat, lx[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [MW-1:0] av, bv;
      logic [W-1:0]  qo, qe;
      logic [2:0]    fo, fe;
      logic          io, ie;
      int            lat;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 500; i++) begin
            av = MW'($urandom) | 24'h800000;
            bv = ($urandom_range(0, 19) == 0) ? (MW'($urandom) & 24'h7FFFFF) : (MW'($urandom) | 24'h800000);
            if (i == 0) av = 24'hFFFFFF;
            if (i == 1) bv = 24'hFFFFFF;
            do_div(k, av, bv, 0, qo, fo, io, lat);
            model(k, av, bv, qe, fe, ie);
            n_cmp++;
            if ({qo, fo, io} !== {qe, fe, ie} || lat != (ie ? 1 : W + 1 + k)) begin
               n_err++;
               $display("FAIL random k=%0d a=%h b=%h: q=%h pnz=%b inv=%b lat=%0d required q=%h pnz=%b inv=%b",
                        k, av, bv, qo, fo, io, lat, qe, fe, ie);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] qo, qe;
      logic [2:0]   fo, fe;
      logic         io, ie;
      int           lat;
      for (int k = 0; k < 2; k++) begin
         do_div(k, 24'hABCDEF, 24'h9A0F11, 5, qo, fo, io, lat);
         model(k, 24'hABCDEF, 24'h9A0F11, qe, fe, ie);
         n_cmp++;
         if ({qo, fo, io} !== {qe, fe, ie}) begin
            n_err++;
            $display("FAIL backpressure k=%0d: q=%h pnz=%b required q=%h pnz=%b", k, qo, fo, qe, fe);
         end
      end
   endtask

   task automatic test_busy_ignored();
      logic [W-1:0] qe;
      logic [2:0]   fe;
      logic         ie, rdy_bad;
      int           n;
      model(1, 24'hF00001, 24'hC12345, qe, fe, ie);
      a[1] = 24'hF00001; b[1] = 24'hC12345; in_valid[1] = 1'b1;
      @(posedge clk); #1;
      a[1] = 24'h800000; b[1] = 24'hFFFFFF;
      rdy_bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (in_ready[1] !== 1'b0) rdy_bad = 1'b1;
         @(posedge clk); #1;
      end
      in_valid[1] = 1'b0;
      n_cmp++;
      if (rdy_bad) begin
         n_err++;
         $display("FAIL busy_in_ready: in_ready=1 while busy required 0");
      end
      n = 0;
      while (!out_valid[1] && n < 100) begin @(posedge clk); #1; n++; end
      n_cmp++;
      if ({out_valid[1], q[1], rpos[1], rneg[1], rzero[1], invalid[1]} !== {1'b1, qe, fe, ie}) begin
         n_err++;
         $display("FAIL busy_result: v=%b q=%h required v=1 q=%h", out_valid[1], q[1], qe);
      end
      out_ready[1] = 1'b1;
      @(posedge clk); #1;
      out_ready[1] = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic rose;
      a[0] = 24'hC00000; b[0] = 24'h900000; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || q[0] !== '0) begin
         n_err++;
         $display("FAIL reset_mid_abort: v=%b rdy=%b q=%h required 0 1 0", out_valid[0], in_ready[0], q[0]);
      end
      #3 rst_n = 1'b1;
      rose = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid[0] !== 1'b0) rose = 1'b1;
      end
      n_cmp++;
      if (rose || in_ready[0] !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid_quiet: out_valid rose=%b in_ready=%b required 0/1", rose, in_ready[0]);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_directed();
      test_backpressure();
      test_busy_ignored();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
